// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux2_pkg.sv
// Shared types for the 1-to-2 packet demultiplexer.
// Provides the packet-lock FSM state encoding.
package gf180mcu_fd_sc_mcu7t5v0__demux2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux2_oreg.sv
// One-entry output holding register with completed-packet counter.
// Ports: clk/rst, load_i/d_i/last_i (beat in), rdy_i (downstream ready),
//        data_o/last_o/valid_o (held beat), pkt_o (wrapping packet count).
module gf180mcu_fd_sc_mcu7t5v0__demux2_oreg
    import gf180mcu_fd_sc_mcu7t5v0__demux2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             last_i,
    input  logic             rdy_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             valid_o,
    output logic [CNTW-1:0]  pkt_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [CNTW-1:0]  pkt_q, pkt_d;
    logic             xfer;

    assign xfer = valid_q & rdy_i;

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        pkt_d   = pkt_q;
        // A drain frees the slot unless a new beat lands the same edge.
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            data_d  = d_i;
            last_d  = last_i;
            valid_d = 1'b1;
        end
        if (xfer && last_q) begin
            pkt_d = pkt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign data_o  = data_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;
    assign pkt_o   = pkt_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux2_stream.sv
// Registered 1-to-2 packet demux: select sampled on first beat, held to last.
// Ports: CLK/RST, I/IV/IL/IR input stream, S select, Z0*/Z1* output streams,
//        PKT0/PKT1 completed-packet counters.
module gf180mcu_fd_sc_mcu7t5v0__demux2_stream
    import gf180mcu_fd_sc_mcu7t5v0__demux2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic             IV,
    input  logic             IL,
    output logic             IR,
    input  logic             S,
    output logic [WIDTH-1:0] Z0,
    output logic             Z0V,
    output logic             Z0L,
    input  logic             Z0R,
    output logic [WIDTH-1:0] Z1,
    output logic             Z1V,
    output logic             Z1L,
    input  logic             Z1R,
    output logic [CNTW-1:0]  PKT0,
    output logic [CNTW-1:0]  PKT1
);

    state_e state_q, state_d;
    logic   tgt;
    logic   acc;

    // S only matters on a packet's first beat; a locked state ignores it.
    always_comb begin
        tgt = S;
        unique case (state_q)
            LOCK0:   tgt = 1'b0;
            LOCK1:   tgt = 1'b1;
            default: tgt = S;
        endcase
    end

    // Ready looks only at the target slot so a stalled sibling never blocks.
    assign IR  = tgt ? (~Z1V | Z1R) : (~Z0V | Z0R);
    assign acc = IV & IR;

    always_comb begin
        state_d = state_q;
        if (acc) begin
            if (IL) begin
                state_d = IDLE;
            end else begin
                state_d = tgt ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    gf180mcu_fd_sc_mcu7t5v0__demux2_oreg #(
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) u_oreg0 (
        .clk    (CLK),
        .rst    (RST),
        .load_i (acc & ~tgt),
        .d_i    (I),
        .last_i (IL),
        .rdy_i  (Z0R),
        .data_o (Z0),
        .last_o (Z0L),
        .valid_o(Z0V),
        .pkt_o  (PKT0)
    );

    gf180mcu_fd_sc_mcu7t5v0__demux2_oreg #(
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) u_oreg1 (
        .clk    (CLK),
        .rst    (RST),
        .load_i (acc & tgt),
        .d_i    (I),
        .last_i (IL),
        .rdy_i  (Z1R),
        .data_o (Z1),
        .last_o (Z1L),
        .valid_o(Z1V),
        .pkt_o  (PKT1)
    );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__demux2_stream.sv
// Directed bench for the 1-to-2 packet demux.
// Table of per-cycle vectors plus hand sequences for reset and wrap.
module tb_gf180mcu_fd_sc_mcu7t5v0__demux2_stream;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] I = '0;
    logic       IV = 1'b0;
    logic       IL = 1'b0;
    logic       IR;
    logic       S = 1'b0;
    logic [7:0] Z0, Z1;
    logic       Z0V, Z0L, Z1V, Z1L;
    logic       Z0R = 1'b0;
    logic       Z1R = 1'b0;
    logic [7:0] PKT0, PKT1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__demux2_stream #(
        .WIDTH(8),
        .CNTW (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .I   (I),
        .IV  (IV),
        .IL  (IL),
        .IR  (IR),
        .S   (S),
        .Z0  (Z0),
        .Z0V (Z0V),
        .Z0L (Z0L),
        .Z0R (Z0R),
        .Z1  (Z1),
        .Z1V (Z1V),
        .Z1L (Z1L),
        .Z1R (Z1R),
        .PKT0(PKT0),
        .PKT1(PKT1)
    );

    typedef struct {
        logic       s;
        logic       iv;
        logic       il;
        logic [7:0] i;
        logic       z0r;
        logic       z1r;
        logic       ir;
        logic       z0v;
        logic [7:0] z0;
        logic       z0l;
        logic       z1v;
        logic [7:0] z1;
        logic       z1l;
        logic [7:0] p0;
        logic [7:0] p1;
    } vec_t;

    function automatic logic [35:0] outs();
        return {Z0V, Z0, Z0L, Z1V, Z1, Z1L, PKT0, PKT1};
    endfunction

    task automatic chk(input string nm, input logic [35:0] act,
                       input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, check IR there, check outputs after rise.
    task automatic run_vec(input string nm, input vec_t v);
        @(negedge CLK);
        S   = v.s;
        IV  = v.iv;
        IL  = v.il;
        I   = v.i;
        Z0R = v.z0r;
        Z1R = v.z1r;
        #1;
        chk({nm, ".ir"}, {35'd0, IR}, {35'd0, v.ir});
        @(posedge CLK);
        #1;
        chk({nm, ".out"}, outs(),
            {v.z0v, v.z0, v.z0l, v.z1v, v.z1, v.z1l, v.p0, v.p1});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        IV  = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    vec_t tbl[11];
    vec_t v;

    initial begin
        //         s     iv    il    i      z0r   z1r   ir    z0v   z0     z0l   z1v   z1     z1l   p0    p1
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h01, 1'b0, 8'd1, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h02, 1'b0, 8'd1, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h03, 1'b1, 8'd1, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h03, 1'b1, 8'd1, 8'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h03, 1'b1, 8'd1, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h03, 1'b1, 8'd1, 8'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 8'h33, 1'b1, 8'd1, 8'd1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h33, 1'b1, 8'd2, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 8'h33, 1'b1, 8'd3, 8'd2};

        do_reset();
        #1;
        chk("reset.out", outs(), 36'd0);
        chk("reset.ir", {35'd0, IR}, 36'd1);

        for (int k = 0; k < 11; k++) begin
            run_vec($sformatf("tbl%0d", k), tbl[k]);
        end

        // Two beats of a 4-beat packet to Z0, then reset mid-packet.
        v = '{1'b0, 1'b1, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 8'h33, 1'b1, 8'd3, 8'd2};
        run_vec("mid.b1", v);
        v = '{1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h33, 1'b1, 8'd3, 8'd2};
        run_vec("mid.b2", v);
        @(negedge CLK);
        RST = 1'b1;
        IV  = 1'b0;
        Z0R = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid.rst", outs(), 36'd0);
        @(negedge CLK);
        RST = 1'b0;
        // Lock must be released: S=1 routes to Z1 even with Z0R low.
        v = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1, 8'd0, 8'd0};
        run_vec("mid.after", v);

        // Alternating single-beat packets at full rate until counters wrap.
        do_reset();
        for (int j = 0; j < 512; j++) begin
            @(negedge CLK);
            S   = j[0];
            IV  = 1'b1;
            IL  = 1'b1;
            I   = j[7:0];
            Z0R = 1'b1;
            Z1R = 1'b1;
            #1;
            chk($sformatf("alt%0d.ir", j), {35'd0, IR}, 36'd1);
            @(posedge CLK);
            #1;
            if (j[0]) begin
                chk($sformatf("alt%0d.z1", j), {27'd0, Z1V, Z1}, {27'd0, 1'b1, j[7:0]});
            end else begin
                chk($sformatf("alt%0d.z0", j), {27'd0, Z0V, Z0}, {27'd0, 1'b1, j[7:0]});
            end
            if (j == 509) begin
                @(negedge CLK);
                IV = 1'b0;
                @(posedge CLK);
                #1;
                chk("alt.p255", {20'd0, PKT0, PKT1}, {20'd0, 8'd255, 8'd255});
            end
        end
        @(negedge CLK);
        IV = 1'b0;
        @(posedge CLK);
        #1;
        chk("alt.wrap", {18'd0, Z0V, Z1V, PKT0, PKT1}, 36'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
